beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Timing and console-mode sequencer for the hardwired CPU controller.
- Latches the console mode from swc/swb/swa on a start-button (qd) press and generates one-hot machine beats w1/w2/w3 on t3.
- Honours the controller's short/long/stop requests and maintains the ST0 console-phase flag.
- Its w1/w2/w3, st0 and mode outputs feed the controller's w*, st0 and sw* inputs.

Parameters:
SYNC_STAGES, 2, flops in the qd synchronizer (min 2).
CNT_W, 16, width of the completed-machine-cycle counter.

Ports:
t3  input  1  clock, rising edge active
clr  input  1  asynchronous active-low reset
qd  input  1  start pushbutton, asynchronous, level
swa  input  1  console mode switch bit 0
swb  input  1  console mode switch bit 1
swc  input  1  console mode switch bit 2
short  input  1  from controller: end cycle after W1
long  input  1  from controller: extend cycle to W3
stop  input  1  from controller: halt after current cycle
sst0  input  1  from controller: set ST0 at end of cycle
w1  output  1  beat 1
w2  output  1  beat 2
w3  output  1  beat 3
st0  output  1  console phase flag
running  output  1  sequencer active
mode  output  3  latched {swc,swb,swa}
mode_err  output  1  last start used an illegal mode
cyc_cnt  output  CNT_W  completed machine cycles

Behaviour:
- clr=0, asynchronous: w1=w2=w3=0, running=0, st0=0, mode=000, mode_err=0, cyc_cnt=0, synchronizer and edge-detect flops cleared. Applies immediately, including mid-cycle.
- qd path:
  - qd passes through SYNC_STAGES flops; the rising-edge detect compares the last stage with one delayed copy.
  - qd first sampled high at edge k gives a start pulse after edge k+SYNC_STAGES-1. w1 rises after edge k+SYNC_STAGES.
- States: IDLE (running=0, all beats 0), W1, W2, W3. Beats are one-hot and registered.
- IDLE + start pulse, sampling {swc,swb,swa}:
  - Legal modes 000 (run program), 001 (write mem), 010 (read mem), 011 (read reg), 100 (write reg): mode latched, mode_err<=0, running<=1, go to W1.
  - Illegal modes 101/110/111: mode latched, mode_err<=1, stay IDLE.
- Beat transitions, one per t3 edge:
  - W1: short=1 ends the cycle; otherwise go to W2.
  - W2: long=1 goes to W3; otherwise the cycle ends.
  - W3: always ends the cycle.
  - short and long both high in W1: short wins.
  - short is ignored in W2/W3; long is ignored in W1/W3.
- End of cycle (the edge leaving the final beat):
  - sst0=1 sampled then: st0<=1.
  - cyc_cnt increments, wrapping at 2^CNT_W.
  - stop=1 sampled then: go to IDLE and running<=0. Otherwise go to W1.
  - stop or sst0 in a non-final beat is ignored.
- st0 is cleared only by clr. It persists through IDLE so the next start sees st0=1.
- While running:
  - Start pulses are discarded, not queued.
  - Switch changes are ignored; mode holds its latched value.
- mode and mode_err hold in IDLE until the next start pulse.

Optional Feature:
- Macro: BEAT_SEQ_CYCLE_COUNT_EN.
- Defined: cyc_cnt counter implemented as described.
- Undefined: no counter flops; the cyc_cnt port remains and is tied to 0.

Test Plan:
- Reset mid-run: clr=0 during W2 -> w1=w2=w3=0, running=0, st0=0, mode=000 with no clock edge; after release, IDLE until qd.
- Run mode: swcba=000, qd=1 (SYNC_STAGES=2), short=long=stop=0 -> w1 two edges after qd is first sampled; beats W1,W2,W1,W2...; cyc_cnt +1 every 2 clocks (macro defined).
- Beat shaping:
  - long=1 in W2 -> W1,W2,W3,W1, cyc_cnt +1.
  - short=1 in W1 -> W1,W1.
  - short=long=1 in W1 -> W1,W1.
- Console two-phase: swcba=100, qd; sst0=1 and stop=1 in W2 -> running=0 after W2, st0=1; second qd -> W1 with st0=1, mode=100.
- Illegal mode: swcba=111, qd -> mode_err=1, mode=111, running=0; then swcba=001, qd -> mode_err=0, mode=001, W1 asserted.
- Ignored inputs while running: qd pulses plus swcba changes during W1/W2 -> no restart, mode unchanged, beat sequence undisturbed; macro undefined -> cyc_cnt=0 always.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: console-mode latch and W1/W2/W3 beat generator for the hardwired controller.
// Optional cycle counter enabled by defining BEAT_SEQ_CYCLE_COUNT_EN; otherwise cyc_cnt is tied to 0.
module beat_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             swa,
  input  logic             swb,
  input  logic             swc,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  input  logic             sst0,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             st0,
  output logic             running,
  output logic [2:0]       mode,
  output logic             mode_err,
  output logic [CNT_W-1:0] cyc_cnt
);
  typedef enum logic [2:0] {IDLE = 3'b000, W1 = 3'b100, W2 = 3'b010, W3 = 3'b001} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic dly, start, legal, fin;
  logic [2:0] sw;
  assign sw = {swc, swb, swa};
  assign legal = sw <= 3'd4;
  assign start = sync[SYNC_STAGES-1] & ~dly;
  assign {w1, w2, w3} = state;
  assign running = |state;
  always_ff @(posedge t3 or negedge clr)
    if (!clr) begin
      sync <= '0;
      dly <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], qd};
      dly <= sync[SYNC_STAGES-1];
    end
  // fin marks the edge that leaves the final beat of a machine cycle
  always_comb begin
    nxt = state;
    fin = 1'b0;
    unique case (state)
      IDLE: nxt = (start && legal) ? W1 : IDLE;
      W1: begin
        fin = short;
        nxt = W2;
      end
      W2: begin
        fin = !long;
        nxt = W3;
      end
      W3: fin = 1'b1;
      default: nxt = IDLE;
    endcase
    if (fin) nxt = stop ? IDLE : W1;
  end
  always_ff @(posedge t3 or negedge clr)
    if (!clr) begin
      state <= IDLE;
      st0 <= 1'b0;
      mode <= 3'b000;
      mode_err <= 1'b0;
    end else begin
      state <= nxt;
      if (fin && sst0) st0 <= 1'b1;
      if (state == IDLE && start) begin
        mode <= sw;
        mode_err <= !legal;
      end
    end
`ifdef BEAT_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge t3 or negedge clr)
    if (!clr) cyc_cnt <= '0;
    else if (fin) cyc_cnt <= cyc_cnt + 1'b1;
`else
  assign cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: scoreboard bench for beat_sequencer; expected cycle counts depend on BEAT_SEQ_CYCLE_COUNT_EN.
module tb_beat_sequencer;
  logic t3 = 0, clr = 1, qd = 0, swa = 0, swb = 0, swc = 0;
  logic short = 0, long = 0, stop = 0, sst0 = 0;
  logic w1, w2, w3, st0, running, mode_err;
  logic [2:0] mode;
  logic [15:0] cyc_cnt;
  int errors = 0, checks = 0, stp = 0;
  typedef struct {
    logic [2:0] b;
    logic r;
    logic s;
    logic [15:0] n;
  } exp_t;
  exp_t q[$];

  beat_sequencer #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .t3(t3), .clr(clr), .qd(qd), .swa(swa), .swb(swb), .swc(swc),
    .short(short), .long(long), .stop(stop), .sst0(sst0),
    .w1(w1), .w2(w2), .w3(w3), .st0(st0), .running(running),
    .mode(mode), .mode_err(mode_err), .cyc_cnt(cyc_cnt)
  );

  always #5 t3 = ~t3;

  function automatic logic [15:0] c(int n);
`ifdef BEAT_SEQ_CYCLE_COUNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(logic s, logic l, logic p, logic z, logic [2:0] b, logic r, logic st, int n);
    exp_t e;
    {short, long, stop, sst0} = {s, l, p, z};
    q.push_back('{b, r, st, c(n)});
    @(posedge t3);
    #1;
    stp++;
    e = q.pop_front();
    check($sformatf("beats@%0d", stp), {w1, w2, w3}, e.b);
    check($sformatf("running@%0d", stp), running, e.r);
    check($sformatf("st0@%0d", stp), st0, e.s);
    check($sformatf("cyc_cnt@%0d", stp), cyc_cnt, e.n);
  endtask

  task automatic set_sw(logic [2:0] v);
    {swc, swb, swa} = v;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_beats"}, {w1, w2, w3}, 3'b000);
    check({tag, "_running"}, running, 1'b0);
    check({tag, "_st0"}, st0, 1'b0);
    check({tag, "_mode"}, mode, 3'b000);
    check({tag, "_mode_err"}, mode_err, 1'b0);
    check({tag, "_cyc_cnt"}, cyc_cnt, 16'd0);
  endtask

  initial begin
    #2 clr = 0;
    #1 check_zero("reset");
    @(posedge t3);
    @(posedge t3);
    #1 clr = 1;
    // run mode, plain W1/W2 alternation
    set_sw(3'b000);
    qd = 1;
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b100, 1, 0, 0);
    step(0, 0, 0, 0, 3'b010, 1, 0, 0);
    set_sw(3'b011);
    qd = 0;
    step(0, 0, 0, 0, 3'b100, 1, 0, 1);
    qd = 1;
    step(0, 0, 0, 0, 3'b010, 1, 0, 1);
    step(0, 0, 0, 0, 3'b100, 1, 0, 2);
    qd = 0;
    step(0, 0, 0, 0, 3'b010, 1, 0, 2);
    check("mode_held_running", mode, 3'b000);
    // long extends to W3, ignored in W1/W3
    step(0, 1, 0, 0, 3'b001, 1, 0, 2);
    step(0, 1, 0, 0, 3'b100, 1, 0, 3);
    step(0, 1, 0, 0, 3'b010, 1, 0, 3);
    step(0, 0, 0, 0, 3'b100, 1, 0, 4);
    // short ends in W1, wins over long
    step(1, 0, 0, 0, 3'b100, 1, 0, 5);
    step(1, 1, 0, 0, 3'b100, 1, 0, 6);
    step(0, 0, 1, 1, 3'b010, 1, 0, 6);
    step(1, 0, 0, 0, 3'b100, 1, 0, 7);
    step(0, 0, 1, 0, 3'b010, 1, 0, 7);
    step(0, 0, 1, 0, 3'b000, 0, 0, 8);
    // console two-phase
    set_sw(3'b100);
    qd = 1;
    step(0, 0, 0, 0, 3'b000, 0, 0, 8);
    step(0, 0, 0, 0, 3'b000, 0, 0, 8);
    step(0, 0, 0, 0, 3'b100, 1, 0, 8);
    check("console_mode", mode, 3'b100);
    check("console_mode_err", mode_err, 1'b0);
    qd = 0;
    step(0, 0, 1, 1, 3'b010, 1, 0, 8);
    step(0, 0, 1, 1, 3'b000, 0, 1, 9);
    step(0, 0, 0, 0, 3'b000, 0, 1, 9);
    qd = 1;
    step(0, 0, 0, 0, 3'b000, 0, 1, 9);
    step(0, 0, 0, 0, 3'b000, 0, 1, 9);
    step(0, 0, 0, 0, 3'b100, 1, 1, 9);
    check("phase2_mode", mode, 3'b100);
    step(0, 0, 0, 0, 3'b010, 1, 1, 9);
    // asynchronous reset in W2
    #2 clr = 0;
    qd = 0;
    #1 check_zero("midrun");
    @(posedge t3);
    @(posedge t3);
    #1 clr = 1;
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    // illegal mode then legal restart
    set_sw(3'b111);
    qd = 1;
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    check("illegal_mode", mode, 3'b111);
    check("illegal_mode_err", mode_err, 1'b1);
    qd = 0;
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    set_sw(3'b001);
    qd = 1;
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 0, 0, 3'b100, 1, 0, 0);
    check("legal_mode", mode, 3'b001);
    check("legal_mode_err", mode_err, 1'b0);
    step(0, 0, 0, 0, 3'b010, 1, 0, 0);
    step(0, 0, 0, 0, 3'b100, 1, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
